// File: rtl/store_if.sv
// Request-side and AXI4 write-channel bundle for the store unit.
// The store unit connects through the master modport; a memory model or interconnect uses slave.
interface store_if #(
   parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
   parameter int C_M_AXI_ADDR_WIDTH      = 32,
   parameter int C_M_AXI_DATA_WIDTH      = 32,
   parameter int C_M_AXI_AWUSER_WIDTH    = 1,
   parameter int C_M_AXI_WUSER_WIDTH     = 4,
   parameter int C_M_AXI_BUSER_WIDTH     = 1
);
   logic                                MEM_WAIT;
   logic                                I_VALID;
   logic [31:0]                         I_ADDR;
   logic [31:0]                         I_DATA;
   logic [3:0]                          I_STRB;
   logic                                O_VALID;
   logic [1:0]                          O_RESP;

   logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_AWID;
   logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR;
   logic [7:0]                          M_AXI_AWLEN;
   logic [2:0]                          M_AXI_AWSIZE;
   logic [1:0]                          M_AXI_AWBURST;
   logic                                M_AXI_AWLOCK;
   logic [3:0]                          M_AXI_AWCACHE;
   logic [2:0]                          M_AXI_AWPROT;
   logic [3:0]                          M_AXI_AWQOS;
   logic [C_M_AXI_AWUSER_WIDTH-1:0]     M_AXI_AWUSER;
   logic                                M_AXI_AWVALID;
   logic                                M_AXI_AWREADY;

   logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_WDATA;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB;
   logic                                M_AXI_WLAST;
   logic [C_M_AXI_WUSER_WIDTH-1:0]      M_AXI_WUSER;
   logic                                M_AXI_WVALID;
   logic                                M_AXI_WREADY;

   logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_BID;
   logic [1:0]                          M_AXI_BRESP;
   logic [C_M_AXI_BUSER_WIDTH-1:0]      M_AXI_BUSER;
   logic                                M_AXI_BVALID;
   logic                                M_AXI_BREADY;

   modport master (
      input  I_VALID, I_ADDR, I_DATA, I_STRB,
      input  M_AXI_AWREADY, M_AXI_WREADY,
      input  M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID,
      output MEM_WAIT, O_VALID, O_RESP,
      output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
      output M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
      output M_AXI_AWVALID,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
      output M_AXI_BREADY
   );

   modport slave (
      output I_VALID, I_ADDR, I_DATA, I_STRB,
      output M_AXI_AWREADY, M_AXI_WREADY,
      output M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID,
      input  MEM_WAIT, O_VALID, O_RESP,
      input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
      input  M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
      input  M_AXI_AWVALID,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
      input  M_AXI_BREADY
   );
endinterface

// File: rtl/store.sv
// AXI4 single-beat write master: one 32-bit store in flight, completion pulse with BRESP.
// Optional STORE_PENDING_EN adds a one-entry pending register so the next store overlaps the current one.
module store (
   input  logic     CLK,
   input  logic     RST,
   store_if.master  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  strb_q, strb_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        ovalid_q, ovalid_d;
   logic [1:0]  oresp_q, oresp_d;

   logic busy, b_hs, aw_left, w_left;
   logic unused_ok;

   assign busy    = (state_q != IDLE);
   assign b_hs    = bus.M_AXI_BVALID && bready_q;
   // A channel still owes a handshake after this edge only if VALID is up and READY is not.
   assign aw_left = awvalid_q && !bus.M_AXI_AWREADY;
   assign w_left  = wvalid_q && !bus.M_AXI_WREADY;
   assign unused_ok = ^{bus.M_AXI_BID, bus.M_AXI_BUSER, bus.I_ADDR[1:0]};

`ifdef STORE_PENDING_EN
   logic        pend_q, pend_d;
   logic [29:0] paddr_q, paddr_d;
   logic [31:0] pdata_q, pdata_d;
   logic [3:0]  pstrb_q, pstrb_d;

   assign bus.MEM_WAIT = busy && pend_q;
`else
   assign bus.MEM_WAIT = busy;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      ovalid_d  = 1'b0;
      oresp_d   = oresp_q;
`ifdef STORE_PENDING_EN
      pend_d    = pend_q;
      paddr_d   = paddr_q;
      pdata_d   = pdata_q;
      pstrb_d   = pstrb_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.I_VALID) begin
               addr_d    = bus.I_ADDR[31:2];
               data_d    = bus.I_DATA;
               strb_d    = bus.I_STRB;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            awvalid_d = aw_left;
            wvalid_d  = w_left;
            if (!aw_left && !w_left) begin
               bready_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (b_hs) begin
               bready_d = 1'b0;
               ovalid_d = 1'b1;
               oresp_d  = bus.M_AXI_BRESP;
               state_d  = IDLE;
`ifdef STORE_PENDING_EN
               if (pend_q) begin
                  addr_d    = paddr_q;
                  data_d    = pdata_q;
                  strb_d    = pstrb_q;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  pend_d    = 1'b0;
                  state_d   = SEND;
               end else if (bus.I_VALID) begin
                  // A request arriving on the completing cycle skips the pending slot.
                  addr_d    = bus.I_ADDR[31:2];
                  data_d    = bus.I_DATA;
                  strb_d    = bus.I_STRB;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = SEND;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef STORE_PENDING_EN
      if (busy && !pend_q && bus.I_VALID && !b_hs) begin
         pend_d  = 1'b1;
         paddr_d = bus.I_ADDR[31:2];
         pdata_d = bus.I_DATA;
         pstrb_d = bus.I_STRB;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         ovalid_q  <= 1'b0;
         oresp_q   <= '0;
`ifdef STORE_PENDING_EN
         pend_q    <= 1'b0;
         paddr_q   <= '0;
         pdata_q   <= '0;
         pstrb_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         ovalid_q  <= ovalid_d;
         oresp_q   <= oresp_d;
`ifdef STORE_PENDING_EN
         pend_q    <= pend_d;
         paddr_q   <= paddr_d;
         pdata_q   <= pdata_d;
         pstrb_q   <= pstrb_d;
`endif
      end
   end

   assign bus.O_VALID       = ovalid_q;
   assign bus.O_RESP        = oresp_q;
   assign bus.M_AXI_AWID    = '0;
   assign bus.M_AXI_AWADDR  = {addr_q, 2'b00};
   assign bus.M_AXI_AWLEN   = 8'd0;
   assign bus.M_AXI_AWSIZE  = 3'b010;
   assign bus.M_AXI_AWBURST = 2'b01;
   assign bus.M_AXI_AWLOCK  = 1'b0;
   assign bus.M_AXI_AWCACHE = 4'b0011;
   assign bus.M_AXI_AWPROT  = 3'b000;
   assign bus.M_AXI_AWQOS   = 4'b0000;
   assign bus.M_AXI_AWUSER  = '0;
   assign bus.M_AXI_AWVALID = awvalid_q;
   assign bus.M_AXI_WDATA   = data_q;
   assign bus.M_AXI_WSTRB   = strb_q;
   assign bus.M_AXI_WLAST   = wvalid_q;
   assign bus.M_AXI_WUSER   = '0;
   assign bus.M_AXI_WVALID  = wvalid_q;
   assign bus.M_AXI_BREADY  = bready_q;
endmodule

// File: tb/tb_store.sv
// Bench for store: AXI slave with per-transaction READY/BVALID delays and a transaction-level
// reference model (request queue, handshake counters) checked every cycle on the falling edge.
module tb_store;
`ifdef STORE_PENDING_EN
   localparam int MW_LIM = 2;
   localparam int GAP    = 2;
`else
   localparam int MW_LIM = 1;
   localparam int GAP    = 3;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } req_t;

   logic CLK = 1'b0;
   logic RST;
   store_if bus ();

   store dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model state
   req_t stim_q[$];
   req_t aw_q[$];
   req_t w_q[$];
   int   acc_cyc_q[$];
   int   n_acc = 0, n_aw = 0, n_w = 0, n_b = 0, inflight = 0;
   int   n_done = 0, cyc = 0, last_ov = -1;
   logic ov_exp = 1'b0;
   logic [1:0] last_resp = 2'b00;
   bit   chk_lat = 0, chk_gap = 0, rand_idle = 0;

   // slave knobs: negative means randomise per transaction
   int k_aw = 0, k_w = 0, k_b = 0, k_resp = 0;
   int aw_dly = 0, w_dly = 0, b_dly = 0;
   int aw_age = 0, w_age = 0, b_age = 0;
   logic [1:0] b_resp = 2'b00;

   function automatic int roll(input int k);
      return (k < 0) ? int'($urandom_range(0, 3)) : k;
   endfunction

   task automatic set_knobs(input int a, input int w, input int b, input int r);
      k_aw = a; k_w = w; k_b = b; k_resp = r;
      aw_dly = roll(a); w_dly = roll(w); b_dly = roll(b);
      b_resp = 2'(roll(r));
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      req_t r;
      r.addr = a; r.data = d; r.strb = s;
      stim_q.push_back(r);
   endtask

   task automatic step(input bit do_rst);
      logic exp_aw, exp_w, exp_b, acc, aw_hs, w_hs, b_hs;
      int lat;
      @(negedge CLK);
      cyc++;
      // a channel is owed when its store is accepted, launched (previous B done) and not yet handshaken
      exp_aw = (n_acc > n_aw) && (n_aw == n_b);
      exp_w  = (n_acc > n_w) && (n_w == n_b);
      exp_b  = (n_aw > n_b) && (n_w > n_b);
      chk("awvalid", bus.M_AXI_AWVALID, exp_aw);
      chk("wvalid", bus.M_AXI_WVALID, exp_w);
      chk("wlast", bus.M_AXI_WLAST, exp_w);
      chk("bready", bus.M_AXI_BREADY, exp_b);
      chk("mem_wait", bus.MEM_WAIT, inflight >= MW_LIM);
      chk("o_valid", bus.O_VALID, ov_exp);
      chk("o_resp", bus.O_RESP, last_resp);
      chk("aw_const", {bus.M_AXI_AWID, bus.M_AXI_AWLEN, bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST,
                       bus.M_AXI_AWLOCK, bus.M_AXI_AWCACHE, bus.M_AXI_AWPROT, bus.M_AXI_AWQOS,
                       bus.M_AXI_AWUSER, bus.M_AXI_WUSER},
                      {1'b0, 8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0, 4'd0});
      if (bus.M_AXI_AWVALID && aw_q.size() > 0)
         chk("awaddr", bus.M_AXI_AWADDR, {aw_q[0].addr[31:2], 2'b00});
      if (bus.M_AXI_WVALID && w_q.size() > 0)
         chk("wdata_wstrb", {bus.M_AXI_WDATA, bus.M_AXI_WSTRB}, {w_q[0].data, w_q[0].strb});
      if (bus.O_VALID && ov_exp && acc_cyc_q.size() > 0) begin
         lat = cyc - acc_cyc_q.pop_front();
         n_done++;
         if (chk_lat) chk("latency", lat, 3);
         if (chk_gap && last_ov >= 0) chk("ov_gap", cyc - last_ov, GAP);
         last_ov = cyc;
      end

      RST = do_rst;
      bus.I_VALID = !do_rst && stim_q.size() > 0 && (!rand_idle || $urandom_range(0, 3) != 0);
      if (stim_q.size() > 0) begin
         bus.I_ADDR = stim_q[0].addr;
         bus.I_DATA = stim_q[0].data;
         bus.I_STRB = stim_q[0].strb;
      end
      bus.M_AXI_AWREADY = (aw_age >= aw_dly);
      bus.M_AXI_WREADY  = (w_age >= w_dly);
      bus.M_AXI_BVALID  = exp_b && (b_age >= b_dly);
      bus.M_AXI_BRESP   = b_resp;
      bus.M_AXI_BID     = 1'($urandom_range(0, 1));
      bus.M_AXI_BUSER   = 1'($urandom_range(0, 1));

      if (do_rst) begin
         stim_q.delete(); aw_q.delete(); w_q.delete(); acc_cyc_q.delete();
         n_acc = 0; n_aw = 0; n_w = 0; n_b = 0; inflight = 0;
         aw_age = 0; w_age = 0; b_age = 0;
         last_resp = 2'b00; ov_exp = 1'b0;
         return;
      end

      acc   = bus.I_VALID && !bus.MEM_WAIT;
      aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
      w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
      b_hs  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
      ov_exp = b_hs;
      if (b_hs) begin
         last_resp = bus.M_AXI_BRESP;
         n_b++; inflight--; b_age = 0;
         b_dly = roll(k_b); b_resp = 2'(roll(k_resp));
      end else if (exp_b) b_age++;
      if (aw_hs) begin
         if (aw_q.size() > 0) void'(aw_q.pop_front());
         n_aw++; aw_age = 0; aw_dly = roll(k_aw);
      end else if (bus.M_AXI_AWVALID) aw_age++;
      if (w_hs) begin
         if (w_q.size() > 0) void'(w_q.pop_front());
         n_w++; w_age = 0; w_dly = roll(k_w);
      end else if (bus.M_AXI_WVALID) w_age++;
      if (acc) begin
         aw_q.push_back(stim_q[0]);
         w_q.push_back(stim_q[0]);
         void'(stim_q.pop_front());
         acc_cyc_q.push_back(cyc);
         n_acc++; inflight++;
      end
   endtask

   task automatic run_idle(input string tag, input int want);
      int guard = 0;
      n_done = 0;
      while ((stim_q.size() > 0 || inflight > 0 || ov_exp) && guard < 3000) begin
         step(1'b0);
         guard++;
      end
      chk({tag, "_timeout"}, guard >= 3000, 1'b0);
      chk({tag, "_done"}, n_done, want);
   endtask

   initial begin
      int g;
      RST = 1'b1;
      bus.I_VALID = 1'b0; bus.I_ADDR = '0; bus.I_DATA = '0; bus.I_STRB = '0;
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = '0; bus.M_AXI_BID = '0; bus.M_AXI_BUSER = '0;
      repeat (3) @(posedge CLK);
      step(1'b1);
      chk("reset_outputs", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                            bus.O_VALID, bus.O_RESP, bus.MEM_WAIT}, '0);

      // ready-high single write, latency 3
      set_knobs(0, 0, 0, 0);
      chk_lat = 1;
      push(32'h0000_1003, 32'hDEAD_BEEF, 4'hF);
      run_idle("ready_high", 1);
      chk_lat = 0;

      // skewed handshakes both ways
      set_knobs(4, 0, 0, 0);
      push(32'h0000_2004, 32'h1111_2222, 4'h5);
      run_idle("aw_late", 1);
      set_knobs(0, 4, 0, 1);
      push(32'h0000_3008, 32'h3333_4444, 4'hA);
      run_idle("w_late", 1);

      // slave error with delayed BVALID
      set_knobs(0, 0, 5, 2);
      push(32'h0000_400C, 32'h5555_6666, 4'hF);
      run_idle("err_resp", 1);
      chk("err_o_resp", bus.O_RESP, 2'b10);

      // back-to-back with I_VALID held
      set_knobs(0, 0, 0, 0);
      last_ov = -1;
      chk_gap = 1;
      for (int i = 0; i < 8; i++) push(32'h0000_5000 + 32'(i * 4), 32'(i), 4'h3);
      run_idle("b2b", 8);
      chk_gap = 0;

      // reset while AW is stalled
      set_knobs(6, 0, 0, 0);
      push(32'h0000_6000, 32'h7777_8888, 4'hF);
      g = 0;
      while (!bus.M_AXI_AWVALID && g < 10) begin
         step(1'b0);
         g++;
      end
      chk("midop_awvalid_seen", bus.M_AXI_AWVALID, 1'b1);
      step(1'b1);
      step(1'b0);
      chk("midop_reset", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                          bus.O_VALID, bus.MEM_WAIT}, '0);
      set_knobs(0, 0, 0, 3);
      push(32'h0000_7000, 32'h9999_AAAA, 4'hC);
      run_idle("after_reset", 1);

      // random traffic and random slave timing
      set_knobs(-1, -1, -1, -1);
      rand_idle = 1;
      for (int i = 0; i < 60; i++) push($urandom, $urandom, 4'($urandom_range(0, 15)));
      run_idle("random", 60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
